flow_light_decoder: RTL and testbench
=====================================

Name: flow_light_decoder

Overview:
- Receive-side counterpart of the flowing-light one-hot driver. It samples the 4-bit one-hot LED pattern bus and recovers the 2-bit direction-select code that produced each pattern.
- It tracks successive patterns to decide the flow direction (rightward, leftward or hold) and locks once the flow is consistent.
- It sits between the LED pattern bus and status/self-check logic on the board top level.

Parameters:
- LOCK_CNT, 4, number of consecutive consistent steps required to enter LOCKED (legal range 1..15).
- CNT_W, 8, width of Step_Cnt; the counter saturates at 2^CNT_W-1.

Ports:
- CLK_in  input  1  system clock; all logic on the rising edge.
- RST_n_in  input  1  asynchronous active-low reset.
- Sample_en  input  1  qualifies Temp_in for one cycle; ignored when low.
- Temp_in  input  4  LED pattern under observation; expected to be one-hot.
- Dir_Sel_out  output  2  recovered code: 1000->00, 0100->01, 0010->10, 0001->11.
- Valid_out  output  1  Dir_Sel_out holds a code recovered from a legal sample.
- Flow_Dir  output  2  00 unknown, 01 right (code +1 mod 4), 10 left (code -1 mod 4), 11 hold.
- Locked  output  1  flow is consistent for LOCK_CNT steps.
- Err  output  1  one-cycle pulse on an illegal sample or a 2-position jump.
- Step_Cnt  output  CNT_W  consecutive steps in the current Flow_Dir; saturating.

Behaviour:
- Interface: one clock, CLK_in; reset RST_n_in is asynchronous and active-low.
- Reset (RST_n_in low, asynchronous):
  - Dir_Sel_out=00, Valid_out=0, Flow_Dir=00, Locked=0, Err=0, Step_Cnt=0.
  - State=IDLE, prev-code register=00.
  - Reset mid-stream discards all history. The first sample after release is treated as the first sample ever.
- Latency: all outputs are registered and update on the rising edge where Sample_en=1. Inputs of cycle N are visible after edge N. With Sample_en=0, every output holds, except Err, which returns to 0.
- Legality: Temp_in is legal iff exactly one bit is set. 0000, or more than one bit set, is illegal.
- Illegal sample:
  - Err=1 for one cycle; Valid_out=0.
  - Dir_Sel_out, Flow_Dir and Step_Cnt hold; Locked=0.
  - State -> IDLE.
- Legal sample: Dir_Sel_out=code, Valid_out=1. Compute delta = (code - prev) mod 4 in 2-bit arithmetic. prev <= code.
- State IDLE:
  - Legal sample -> TRACK; Flow_Dir=00, Step_Cnt=0.
- State TRACK (delta 0 = hold, 1 = right, 3 = left):
  - delta 2 (jump): Err pulse, Flow_Dir=00, Step_Cnt=0, stay TRACK.
  - Otherwise, if the new direction equals the current Flow_Dir, Step_Cnt+1; else Flow_Dir=new direction, Step_Cnt=1.
  - If the resulting Step_Cnt >= LOCK_CNT -> LOCKED; Locked=1 on the same edge.
- State LOCKED:
  - Same direction: Step_Cnt+1 (saturating), Locked stays 1.
  - Different direction or jump: Locked=0 and -> TRACK. Flow_Dir=new direction (00 on a jump), Step_Cnt=1 (0 on a jump); a jump also pulses Err.
  - Illegal sample: -> IDLE as above.
- Saturation: Step_Cnt holds at 2^CNT_W-1 and never wraps.
- Wrap-around: 0001->1000 is delta 1 (right); 1000->0001 is delta 3 (left).
- Back-to-back Sample_en on consecutive cycles is supported with no bubble.

Test Plan:
- Reset then Temp_in 1000,0100,0010,0001,1000 with Sample_en each cycle -> Dir_Sel_out 00,01,10,11,00; Flow_Dir 00 then 01; Step_Cnt 0,1,2,3,4; Locked=1 after the 5th sample (LOCK_CNT=4).
- Locked-right stream, then 0100 followed by 1000 -> Flow_Dir=10, Step_Cnt=1, Locked=0, Err=0.
- Temp_in 0110 while LOCKED -> Err=1 for exactly one cycle, Valid_out=0, Locked=0; next legal 0010 gives Valid_out=1, Flow_Dir=00, Step_Cnt=0.
- 1000 then 0010 (jump) -> Err pulse, Flow_Dir=00, Step_Cnt=0, Dir_Sel_out=10.
- Repeated 0100 for 300 samples with CNT_W=8 -> Flow_Dir=11, Locked=1, Step_Cnt saturates at 255.
- RST_n_in pulsed low asynchronously between edges while LOCKED -> all outputs clear immediately; first post-reset sample 0001 gives Dir_Sel_out=11, Flow_Dir=00.

Source files
------------

// File: rtl/flow_light_decoder_if.sv
// flow_light_decoder_if: bundles the LED pattern sample and the decoded
// status outputs of flow_light_decoder.
//   Sample_en   - qualifies Temp_in for one cycle
//   Temp_in     - observed 4-bit LED pattern (expected one-hot)
//   Dir_Sel_out - recovered 2-bit direction-select code
//   Valid_out   - Dir_Sel_out came from a legal sample
//   Flow_Dir    - 00 unknown, 01 right, 10 left, 11 hold
//   Locked      - flow has been consistent long enough
//   Err         - one-cycle pulse on illegal sample or 2-position jump
//   Step_Cnt    - consecutive steps in the current Flow_Dir (saturating)
// master: pattern source / status consumer. slave: the decoder.
interface flow_light_decoder_if #(
    parameter int CNT_W = 8
);
    logic             Sample_en;
    logic [3:0]       Temp_in;
    logic [1:0]       Dir_Sel_out;
    logic             Valid_out;
    logic [1:0]       Flow_Dir;
    logic             Locked;
    logic             Err;
    logic [CNT_W-1:0] Step_Cnt;

    modport master (
        output Sample_en, Temp_in,
        input  Dir_Sel_out, Valid_out, Flow_Dir, Locked, Err, Step_Cnt
    );

    modport slave (
        input  Sample_en, Temp_in,
        output Dir_Sel_out, Valid_out, Flow_Dir, Locked, Err, Step_Cnt
    );
endinterface

// File: rtl/flow_light_decoder.sv
// flow_light_decoder: samples a one-hot LED pattern, recovers the 2-bit
// direction-select code behind it, classifies successive codes as right,
// left or hold, and locks once the same flow repeats LOCK_CNT steps.
//   CLK_in   - clock, rising edge
//   RST_n_in - asynchronous active-low reset, discards all history
//   bus      - slave side of flow_light_decoder_if (sample in, status out)
// All outputs are registered; with Sample_en low everything holds except
// Err, which drops back to 0.
module flow_light_decoder #(
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic                  CLK_in,
    input  logic                  RST_n_in,
    flow_light_decoder_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    localparam logic [1:0]       DIR_UNK   = 2'b00;
    localparam logic [1:0]       DIR_RIGHT = 2'b01;
    localparam logic [1:0]       DIR_LEFT  = 2'b10;
    localparam logic [1:0]       DIR_HOLD  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] LOCK_THR  = CNT_W'(LOCK_CNT);

    state_t           state_q, state_d;
    logic [1:0]       prev_q, prev_d;
    logic [1:0]       dir_sel_q, dir_sel_d;
    logic             valid_q, valid_d;
    logic [1:0]       flow_q, flow_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             legal;
    logic [1:0]       code;
    logic [1:0]       delta;
    logic [1:0]       new_dir;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        // exactly one bit set: nonzero and clearing the lowest set bit leaves zero
        legal = (bus.Temp_in != 4'b0000) &&
                ((bus.Temp_in & (bus.Temp_in - 4'd1)) == 4'b0000);

        case (bus.Temp_in)
            4'b1000: code = 2'd0;
            4'b0100: code = 2'd1;
            4'b0010: code = 2'd2;
            default: code = 2'd3;
        endcase

        // mod-4 difference makes 0001->1000 a right step for free
        delta = code - prev_q;
        case (delta)
            2'd0:    new_dir = DIR_HOLD;
            2'd1:    new_dir = DIR_RIGHT;
            2'd3:    new_dir = DIR_LEFT;
            default: new_dir = DIR_UNK;
        endcase

        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

        state_d   = state_q;
        prev_d    = prev_q;
        dir_sel_d = dir_sel_q;
        valid_d   = valid_q;
        flow_d    = flow_q;
        locked_d  = locked_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;

        if (bus.Sample_en) begin
            if (!legal) begin
                // keep the last good code/flow visible, but drop the lock
                err_d    = 1'b1;
                valid_d  = 1'b0;
                locked_d = 1'b0;
                state_d  = IDLE;
            end else begin
                dir_sel_d = code;
                valid_d   = 1'b1;
                prev_d    = code;
                if (state_q == IDLE) begin
                    // first sample has no predecessor to compare against
                    state_d  = TRACK;
                    flow_d   = DIR_UNK;
                    cnt_d    = '0;
                    locked_d = 1'b0;
                end else if (delta == 2'd2) begin
                    err_d    = 1'b1;
                    flow_d   = DIR_UNK;
                    cnt_d    = '0;
                    locked_d = 1'b0;
                    state_d  = TRACK;
                end else if (new_dir == flow_q) begin
                    cnt_d = cnt_inc;
                    if (state_q == TRACK && cnt_d >= LOCK_THR) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end
                end else begin
                    flow_d = new_dir;
                    cnt_d  = CNT_ONE;
                    if (state_q == LOCKED) begin
                        // a direction change always unlocks, even if LOCK_CNT is 1
                        state_d  = TRACK;
                        locked_d = 1'b0;
                    end else if (cnt_d >= LOCK_THR) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK_in or negedge RST_n_in) begin
        if (!RST_n_in) begin
            state_q   <= IDLE;
            prev_q    <= 2'b00;
            dir_sel_q <= 2'b00;
            valid_q   <= 1'b0;
            flow_q    <= DIR_UNK;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            dir_sel_q <= dir_sel_d;
            valid_q   <= valid_d;
            flow_q    <= flow_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.Dir_Sel_out = dir_sel_q;
    assign bus.Valid_out   = valid_q;
    assign bus.Flow_Dir    = flow_q;
    assign bus.Locked      = locked_q;
    assign bus.Err         = err_q;
    assign bus.Step_Cnt    = cnt_q;

endmodule

// File: tb/tb_flow_light_decoder.sv
// tb_flow_light_decoder: directed vectors with hand-computed expectations.
// The stimulus process pushes the expected post-edge outputs into a queue;
// a monitor pops one entry after each edge (or after an asynchronous reset
// request) and compares it with the DUT outputs.
module tb_flow_light_decoder;

    typedef struct packed {
        logic [1:0] dsel;
        logic       vld;
        logic [1:0] flow;
        logic       lk;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    string name_q[$];
    event rst_ev;

    flow_light_decoder_if #(.CNT_W(8)) bus ();

    flow_light_decoder #(.LOCK_CNT(4), .CNT_W(8)) dut (
        .CLK_in  (clk),
        .RST_n_in(rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: compares after every rising edge, or right after a reset request
    initial begin
        exp_t e;
        exp_t a;
        string nm;
        forever begin
            @(posedge clk or rst_ev);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = '{bus.Dir_Sel_out, bus.Valid_out, bus.Flow_Dir,
                       bus.Locked, bus.Err, bus.Step_Cnt};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got dsel=%b vld=%b flow=%b lk=%b err=%b cnt=%0d, want dsel=%b vld=%b flow=%b lk=%b err=%b cnt=%0d",
                             nm, a.dsel, a.vld, a.flow, a.lk, a.err, a.cnt,
                             e.dsel, e.vld, e.flow, e.lk, e.err, e.cnt);
                end
            end
        end
    end

    task automatic step(input string nm, input logic en, input logic [3:0] t,
                        input logic [1:0] dsel, input logic vld, input logic [1:0] flow,
                        input logic lk, input logic err, input int cnt);
        @(negedge clk);
        bus.Sample_en = en;
        bus.Temp_in   = t;
        exp_q.push_back('{dsel, vld, flow, lk, err, cnt[7:0]});
        name_q.push_back(nm);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (exp_q.size() > 0) begin
            $display("FAIL drain: %0d expected entries never checked, want 0", exp_q.size());
            $fatal(1, "monitor stalled");
        end
    endtask

    // assert reset between edges and have the monitor check the cleared outputs
    task automatic async_reset(input string nm);
        drain();
        @(negedge clk);
        #2;
        bus.Sample_en = 1'b0;
        rst_n = 1'b0;
        exp_q.push_back('{2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 8'd0});
        name_q.push_back(nm);
        -> rst_ev;
        #2;
        drain();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.Sample_en = 1'b0;
        bus.Temp_in   = 4'b0000;
        #13;
        async_reset("reset_state");

        // rightward stream locks after the fifth sample
        step("r0", 1, 4'b1000, 2'b00, 1, 2'b00, 0, 0, 0);
        step("r1", 1, 4'b0100, 2'b01, 1, 2'b01, 0, 0, 1);
        step("r2", 1, 4'b0010, 2'b10, 1, 2'b01, 0, 0, 2);
        step("r3", 1, 4'b0001, 2'b11, 1, 2'b01, 0, 0, 3);
        step("r4_lock", 1, 4'b1000, 2'b00, 1, 2'b01, 1, 0, 4);
        step("r5", 1, 4'b0100, 2'b01, 1, 2'b01, 1, 0, 5);
        // reversal while locked
        step("rev_left", 1, 4'b1000, 2'b00, 1, 2'b10, 0, 0, 1);
        step("idle_hold", 0, 4'b0110, 2'b00, 1, 2'b10, 0, 0, 1);
        step("l2", 1, 4'b0001, 2'b11, 1, 2'b10, 0, 0, 2);
        step("l3", 1, 4'b0010, 2'b10, 1, 2'b10, 0, 0, 3);
        step("l4_lock", 1, 4'b0100, 2'b01, 1, 2'b10, 1, 0, 4);
        // illegal sample while locked, then recovery from IDLE
        step("illegal", 1, 4'b0110, 2'b01, 0, 2'b10, 0, 1, 4);
        step("err_drop", 0, 4'b0000, 2'b01, 0, 2'b10, 0, 0, 4);
        step("recover", 1, 4'b0010, 2'b10, 1, 2'b00, 0, 0, 0);
        // two-position jumps
        step("jump_a", 1, 4'b1000, 2'b00, 1, 2'b00, 0, 1, 0);
        step("jump_b", 1, 4'b0010, 2'b10, 1, 2'b00, 0, 1, 0);
        // wrap-around in both directions
        step("after_jump", 1, 4'b0001, 2'b11, 1, 2'b01, 0, 0, 1);
        step("wrap_right", 1, 4'b1000, 2'b00, 1, 2'b01, 0, 0, 2);
        step("wrap_left", 1, 4'b0001, 2'b11, 1, 2'b10, 0, 0, 1);
        // illegal all-zero and all-ones back to back
        step("zero", 1, 4'b0000, 2'b11, 0, 2'b10, 0, 1, 1);
        step("ones", 1, 4'b1111, 2'b11, 0, 2'b10, 0, 1, 1);

        // hold stream saturates the counter
        async_reset("reset_mid");
        step("hold0", 1, 4'b0100, 2'b01, 1, 2'b00, 0, 0, 0);
        for (int i = 1; i < 300; i++)
            step($sformatf("hold%0d", i), 1, 4'b0100, 2'b01, 1, 2'b11,
                 (i >= 4), 0, (i > 255) ? 255 : i);

        // asynchronous reset while locked discards history
        async_reset("reset_locked");
        step("post_rst", 1, 4'b0001, 2'b11, 1, 2'b00, 0, 0, 0);
        step("post_rst2", 1, 4'b0010, 2'b10, 1, 2'b10, 0, 0, 1);

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
